// File: rtl/punc_control_pkg.sv
// Shared encodings for the PUnC control unit: states, opcodes, mux selects and control word.
package punc_control_pkg;

    localparam int unsigned IR_W    = 16;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_INIT  = 3'd0,
        S_FETCH = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC  = 3'd3,
        S_EXEC2 = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] PC_SEL_OFF9  = 2'd0;
    localparam logic [1:0] PC_SEL_OFF11 = 2'd1;
    localparam logic [1:0] PC_SEL_RQ    = 2'd2;

    localparam logic [1:0] RD_ADDR_PC      = 2'd0;
    localparam logic [1:0] RD_ADDR_OFF9    = 2'd1;
    localparam logic [1:0] RD_ADDR_RP      = 2'd2;
    localparam logic [1:0] RD_ADDR_RQ_OFF6 = 2'd3;

    localparam logic [1:0] WR_ADDR_OFF9    = 2'd0;
    localparam logic [1:0] WR_ADDR_TEMP    = 2'd1;
    localparam logic [1:0] WR_ADDR_RQ_OFF6 = 2'd2;

    localparam logic [1:0] RF_DATA_ALU     = 2'd0;
    localparam logic [1:0] RF_DATA_DMEM    = 2'd1;
    localparam logic [1:0] RF_DATA_PC      = 2'd2;
    localparam logic [1:0] RF_DATA_PC_OFF9 = 2'd3;

    localparam logic RF_ADDR_DR  = 1'b0;
    localparam logic RF_ADDR_R7  = 1'b1;
    localparam logic RP_ADDR_DR  = 1'b0;
    localparam logic RP_ADDR_SR2 = 1'b1;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_AND  = 2'd1;
    localparam logic [1:0] ALU_NOT  = 2'd2;
    localparam logic [1:0] ALU_PASS = 2'd3;

    localparam logic ALU_A_RP   = 1'b0;
    localparam logic ALU_A_IMM5 = 1'b1;

    localparam int unsigned BR_N = 11;
    localparam int unsigned BR_Z = 10;
    localparam int unsigned BR_P = 9;

    typedef struct packed {
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic [1:0] pc_sel;
        logic       ir_ld;
        logic       ir_clr;
        logic       dmem_rd;
        logic       dmem_wr;
        logic [1:0] dmem_r_addr_sel;
        logic [1:0] dmem_w_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_w_addr_sel;
        logic       rf_w_wr;
        logic       rf_rp_addr_sel;
        logic       rf_rp_rd;
        logic       rf_rq_rd;
        logic       temp_ld;
        logic       nzp_ld;
        logic       nzp_clr;
        logic [1:0] alu_sel;
        logic       alu_in_a_sel;
    } ctrl_t;

    function automatic logic [3:0] ir_opcode(input logic [IR_W-1:0] ir);
        return ir[15:12];
    endfunction

endpackage

// File: rtl/punc_if.sv
// Control/datapath boundary: IR and branch match in, control word and status out.
interface punc_if;
    import punc_control_pkg::*;

    logic [IR_W-1:0]    ir;
    logic               nzp_match;
    ctrl_t              ctrl;
    logic               halted;
    logic [STATE_W-1:0] state_debug;

    modport master (input ir, nzp_match, output ctrl, halted, state_debug);
    modport slave  (output ir, nzp_match, input ctrl, halted, state_debug);
endinterface

// File: rtl/punc_control_decode.sv
// Combinational map from (state, IR, nzp_match) to the datapath control word.
module punc_decode
    import punc_control_pkg::*;
(
    input  state_t          state,
    input  logic [IR_W-1:0] ir,
    input  logic            nzp_match,
    output ctrl_t           ctrl
);

    logic [3:0] op;
    logic       unused_ir_bits;

    assign op = ir_opcode(ir);
    // Register fields and offsets are consumed by the datapath, not here.
    assign unused_ir_bits = ^{ir[10:6], ir[4:0]};

    always_comb begin
        ctrl = '0;
        case (state)
            S_INIT: begin
                ctrl.pc_clr  = 1'b1;
                ctrl.ir_clr  = 1'b1;
                ctrl.nzp_clr = 1'b1;
            end
            S_FETCH: begin
                ctrl.dmem_rd         = 1'b1;
                ctrl.dmem_r_addr_sel = RD_ADDR_PC;
                ctrl.ir_ld           = 1'b1;
                ctrl.pc_inc          = 1'b1;
            end
            S_EXEC: begin
                case (op)
                    OP_ADD, OP_AND: begin
                        ctrl.rf_rq_rd       = 1'b1;
                        ctrl.rf_rp_rd       = 1'b1;
                        ctrl.rf_rp_addr_sel = RP_ADDR_SR2;
                        ctrl.alu_in_a_sel   = ir[5] ? ALU_A_IMM5 : ALU_A_RP;
                        ctrl.alu_sel        = (op == OP_AND) ? ALU_AND : ALU_ADD;
                        ctrl.rf_w_data_sel  = RF_DATA_ALU;
                        ctrl.rf_w_wr        = 1'b1;
                        ctrl.nzp_ld         = 1'b1;
                    end
                    OP_NOT: begin
                        ctrl.alu_sel  = ALU_NOT;
                        ctrl.rf_rq_rd = 1'b1;
                        ctrl.rf_w_wr  = 1'b1;
                        ctrl.nzp_ld   = 1'b1;
                    end
                    OP_BR: begin
                        ctrl.pc_ld  = nzp_match;
                        ctrl.pc_sel = PC_SEL_OFF9;
                    end
                    OP_JMP: begin
                        ctrl.pc_ld  = 1'b1;
                        ctrl.pc_sel = PC_SEL_RQ;
                    end
                    OP_JSR: begin
                        ctrl.rf_w_addr_sel = RF_ADDR_R7;
                        ctrl.rf_w_data_sel = RF_DATA_PC;
                        ctrl.rf_w_wr       = 1'b1;
                        ctrl.pc_ld         = 1'b1;
                        ctrl.pc_sel        = ir[11] ? PC_SEL_OFF11 : PC_SEL_RQ;
                    end
                    OP_LD, OP_LDI, OP_LDR: begin
                        // LDI parks the pointer in DR; EXEC2 dereferences it.
                        ctrl.dmem_r_addr_sel = (op == OP_LDR) ? RD_ADDR_RQ_OFF6 : RD_ADDR_OFF9;
                        ctrl.rf_w_data_sel   = RF_DATA_DMEM;
                        ctrl.rf_w_wr         = 1'b1;
                        ctrl.nzp_ld          = 1'b1;
                    end
                    OP_LEA: begin
                        ctrl.rf_w_data_sel = RF_DATA_PC_OFF9;
                        ctrl.rf_w_wr       = 1'b1;
                        ctrl.nzp_ld        = 1'b1;
                    end
                    OP_ST, OP_STR: begin
                        ctrl.rf_rp_addr_sel  = RP_ADDR_DR;
                        ctrl.dmem_w_addr_sel = (op == OP_STR) ? WR_ADDR_RQ_OFF6 : WR_ADDR_OFF9;
                        ctrl.dmem_wr         = 1'b1;
                    end
                    OP_STI: begin
                        ctrl.dmem_r_addr_sel = RD_ADDR_OFF9;
                        ctrl.temp_ld         = 1'b1;
                    end
                    OP_RTI, OP_RES: ;
                    default: ;
                endcase
            end
            S_EXEC2: begin
                if (op == OP_LDI) begin
                    ctrl.dmem_r_addr_sel = RD_ADDR_RP;
                    ctrl.rf_rp_addr_sel  = RP_ADDR_DR;
                    ctrl.rf_w_data_sel   = RF_DATA_DMEM;
                    ctrl.rf_w_wr         = 1'b1;
                    ctrl.nzp_ld          = 1'b1;
                end else if (op == OP_STI) begin
                    ctrl.rf_rp_addr_sel  = RP_ADDR_DR;
                    ctrl.dmem_w_addr_sel = WR_ADDR_TEMP;
                    ctrl.dmem_wr         = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/punc_control.sv
// PUnC control unit: FETCH/DECODE/EXEC sequencer driving the datapath control word.
module punc_control
    import punc_control_pkg::*;
(
    input logic   clk,
    input logic   rst,
    punc_if.master bus
);

    state_t state;
    ctrl_t  dec_ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            case (state)
                S_INIT:   state <= S_FETCH;
                S_FETCH:  state <= S_DECODE;
                S_DECODE: state <= (ir_opcode(bus.ir) == OP_HALT) ? S_HALT : S_EXEC;
                S_EXEC:   state <= (ir_opcode(bus.ir) == OP_LDI || ir_opcode(bus.ir) == OP_STI)
                                   ? S_EXEC2 : S_FETCH;
                S_EXEC2:  state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_INIT;
            endcase
        end
    end

    punc_decode u_decode (
        .state     (state),
        .ir        (bus.ir),
        .nzp_match (bus.nzp_match),
        .ctrl      (dec_ctrl)
    );

    // Control word is state+IR decode; reset forces it idle so an aborted instruction cannot write.
    assign bus.ctrl        = rst ? '0 : dec_ctrl;
    assign bus.halted      = !rst && (state == S_HALT);
    assign bus.state_debug = rst ? STATE_W'(0) : STATE_W'(state);

endmodule

// File: tb/tb_punc_control.sv
// Bench for punc_control: directed spot checks plus random instruction stream against a behavioural model.
module tb_punc_control;
    import punc_control_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    punc_if bus ();
    punc_control dut (.clk(clk), .rst(rst), .bus(bus));

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          m_state  = 0;   // 0 INIT,1 FETCH,2 DECODE,3 EXEC,4 EXEC2,5 HALT

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic int model_next(input int st, input logic [3:0] op);
        case (st)
            0: return 1;
            1: return 2;
            2: return (op == 4'hF) ? 5 : 3;
            3: return (op == 4'hA || op == 4'hB) ? 4 : 1;
            4: return 1;
            5: return 5;
            default: return 0;
        endcase
    endfunction

    // Control word the spec's per-state/per-opcode tables call for.
    function automatic ctrl_t model(input int st, input logic [15:0] i, input logic nzp, input logic r);
        ctrl_t c;
        logic [3:0] op;
        c  = '0;
        op = i[15:12];
        if (r) return c;
        if (st == 0) begin
            c.pc_clr = 1; c.ir_clr = 1; c.nzp_clr = 1;
        end else if (st == 1) begin
            c.dmem_rd = 1; c.ir_ld = 1; c.pc_inc = 1;
        end else if (st == 3) begin
            case (op)
                4'h1, 4'h5: begin
                    c.rf_rq_rd = 1; c.rf_rp_rd = 1; c.rf_rp_addr_sel = 1;
                    c.alu_in_a_sel = i[5]; c.alu_sel = (op == 4'h5) ? 2'd1 : 2'd0;
                    c.rf_w_wr = 1; c.nzp_ld = 1;
                end
                4'h9: begin c.alu_sel = 2'd2; c.rf_rq_rd = 1; c.rf_w_wr = 1; c.nzp_ld = 1; end
                4'h0: c.pc_ld = nzp;
                4'hC: begin c.pc_ld = 1; c.pc_sel = 2'd2; end
                4'h4: begin
                    c.rf_w_addr_sel = 1; c.rf_w_data_sel = 2'd2; c.rf_w_wr = 1;
                    c.pc_ld = 1; c.pc_sel = i[11] ? 2'd1 : 2'd2;
                end
                4'h2, 4'hA: begin c.dmem_r_addr_sel = 2'd1; c.rf_w_data_sel = 2'd1; c.rf_w_wr = 1; c.nzp_ld = 1; end
                4'h6: begin c.dmem_r_addr_sel = 2'd3; c.rf_w_data_sel = 2'd1; c.rf_w_wr = 1; c.nzp_ld = 1; end
                4'hE: begin c.rf_w_data_sel = 2'd3; c.rf_w_wr = 1; c.nzp_ld = 1; end
                4'h3: c.dmem_wr = 1;
                4'h7: begin c.dmem_wr = 1; c.dmem_w_addr_sel = 2'd2; end
                4'hB: begin c.dmem_r_addr_sel = 2'd1; c.temp_ld = 1; end
                default: ;
            endcase
        end else if (st == 4) begin
            if (op == 4'hA) begin
                c.dmem_r_addr_sel = 2'd2; c.rf_w_data_sel = 2'd1; c.rf_w_wr = 1; c.nzp_ld = 1;
            end else if (op == 4'hB) begin
                c.dmem_w_addr_sel = 2'd1; c.dmem_wr = 1;
            end
        end
        return c;
    endfunction

    always @(posedge clk) m_state <= rst ? 0 : model_next(m_state, bus.ir[15:12]);

    // Every-cycle comparison of the full control word and status against the model.
    always @(negedge clk) begin
        ctrl_t e;
        logic [3:0] es;
        e  = model(m_state, bus.ir, bus.nzp_match, rst);
        es = rst ? 4'd0 : {m_state == 5, 3'(m_state)};
        chk("ctrl_word", 32'(bus.ctrl), 32'(e));
        chk("halted_state", 32'({bus.halted, bus.state_debug}), 32'(es));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // From FETCH: the datapath loads IR at the FETCH edge, then run into EXEC.
    task automatic to_exec(input logic [15:0] v, input logic n);
        tick();
        bus.ir = v;
        bus.nzp_match = n;
        tick();
        #1;
    endtask

    initial begin
        bus.ir = 16'h0000;
        bus.nzp_match = 1'b0;

        tick(); #1;
        chk("rst_idle", 32'(bus.ctrl), 32'd0);
        rst = 1'b0; #1;
        chk("init_pc_clr", 32'(bus.ctrl.pc_clr), 1);
        chk("init_ir_clr", 32'(bus.ctrl.ir_clr), 1);
        chk("init_nzp_clr", 32'(bus.ctrl.nzp_clr), 1);
        tick(); #1;
        chk("fetch_ir_ld", 32'(bus.ctrl.ir_ld), 1);
        chk("fetch_pc_inc", 32'(bus.ctrl.pc_inc), 1);

        to_exec(16'h1262, 1'b0);
        chk("add_state", 32'(bus.state_debug), 3);
        chk("add_alu_in_a", 32'(bus.ctrl.alu_in_a_sel), 1);
        chk("add_alu_sel", 32'(bus.ctrl.alu_sel), 0);
        chk("add_rf_w_wr", 32'(bus.ctrl.rf_w_wr), 1);
        chk("add_nzp_ld", 32'(bus.ctrl.nzp_ld), 1);
        tick(); #1;
        chk("add_back_fetch", 32'(bus.state_debug), 1);

        to_exec(16'h0A05, 1'b0);
        chk("br_nt_pc_ld", 32'(bus.ctrl.pc_ld), 0);
        tick();
        to_exec(16'h0A05, 1'b1);
        chk("br_t_pc_ld", 32'(bus.ctrl.pc_ld), 1);
        chk("br_t_pc_sel", 32'(bus.ctrl.pc_sel), 0);
        tick();

        to_exec(16'h4803, 1'b0);
        chk("jsr_w_addr", 32'(bus.ctrl.rf_w_addr_sel), 1);
        chk("jsr_w_data", 32'(bus.ctrl.rf_w_data_sel), 2);
        chk("jsr_pc_sel", 32'(bus.ctrl.pc_sel), 1);
        chk("jsr_nzp_ld", 32'(bus.ctrl.nzp_ld), 0);
        tick();
        to_exec(16'h4080, 1'b0);
        chk("jsrr_pc_sel", 32'(bus.ctrl.pc_sel), 2);
        tick();

        to_exec(16'hA402, 1'b0);
        chk("ldi_exec_raddr", 32'(bus.ctrl.dmem_r_addr_sel), 1);
        tick(); #1;
        chk("ldi_exec2_state", 32'(bus.state_debug), 4);
        chk("ldi_exec2_raddr", 32'(bus.ctrl.dmem_r_addr_sel), 2);
        chk("ldi_exec2_wr", 32'(bus.ctrl.rf_w_wr), 1);
        tick();

        to_exec(16'hB402, 1'b0);
        chk("sti_temp_ld", 32'(bus.ctrl.temp_ld), 1);
        tick(); #1;
        chk("sti_waddr", 32'(bus.ctrl.dmem_w_addr_sel), 1);
        chk("sti_dmem_wr", 32'(bus.ctrl.dmem_wr), 1);
        tick();

        to_exec(16'h3200, 1'b0);
        chk("st_dmem_wr", 32'(bus.ctrl.dmem_wr), 1);
        rst = 1'b1; #1;
        chk("st_rst_no_wr", 32'(bus.ctrl.dmem_wr), 0);
        tick();
        rst = 1'b0; #1;
        chk("st_rst_init", 32'(bus.state_debug), 0);
        tick();

        to_exec(16'hF025, 1'b0);
        chk("halt_halted", 32'(bus.halted), 1);
        chk("halt_state", 32'(bus.state_debug), 5);
        for (int k = 0; k < 20; k++) begin
            tick(); #1;
            chk("halt_idle", 32'({bus.halted, bus.ctrl}), 32'({1'b1, 26'd0}));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        chk("halt_rst_init", 32'(bus.state_debug), 0);

        // Random instruction stream with occasional resets; the negedge compare does the checking.
        for (int k = 0; k < 3000; k++) begin
            tick();
            rst = ($urandom_range(0, 63) == 0);
            bus.nzp_match = 1'($urandom);
            if (m_state == 2) bus.ir = 16'($urandom);
        end
        rst = 1'b0;
        tick();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
